id_ex_stage: RTL

//  ID/EX pipeline register and operand-forwarding stage of the 16-bit pipeline; its outputs feed ALU2 (a, b, aluOp).

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, ALU op codes and the
// ID/EX register layout used by the forwarding stage.
package pipe_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_MOV  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_NOP  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_ADDI = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SUBI = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_ANDI = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_ORI  = 4'd10;

    // Everything the EX stage remembers about the instruction it holds.
    typedef struct packed {
        logic                  valid;
        logic [ALU_OP_W-1:0]   aluOp;
        logic [REG_ADDR_W-1:0] rsAddr;
        logic [REG_ADDR_W-1:0] rtAddr;
        logic [DATA_W-1:0]     rsData;
        logic [DATA_W-1:0]     rtData;
        logic [DATA_W-1:0]     imm;
        logic                  useImm;
        logic [REG_ADDR_W-1:0] rdAddr;
        logic                  regWrite;
        logic                  memRead;
        logic                  memWrite;
    } ExRegT;

    // A bubble is an all-zero slot that still presents the nop op code to the ALU.
    function automatic ExRegT bubbleReg();
        ExRegT b;
        b       = '0;
        b.aluOp = ALU_NOP;
        return b;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector: picks the youngest in-flight result that targets
// the latched source register, otherwise the value captured from the register file.
module fwd_mux
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]     latched_i,
    input  logic                  exmWrite_i,
    input  logic [REG_ADDR_W-1:0] exmAddr_i,
    input  logic [DATA_W-1:0]     exmData_i,
    input  logic                  mwbWrite_i,
    input  logic [REG_ADDR_W-1:0] mwbAddr_i,
    input  logic [DATA_W-1:0]     mwbData_i,
    output logic [DATA_W-1:0]     operand_o
);

    // r0 is hard-wired to zero, so it never forwards; EX/MEM is younger and wins over MEM/WB.
    always_comb begin
        operand_o = latched_i;
        if (addr_i == '0) begin
            operand_o = '0;
        end else if (exmWrite_i && (exmAddr_i == addr_i)) begin
            operand_o = exmData_i;
        end else if (mwbWrite_i && (mwbAddr_i == addr_i)) begin
            operand_o = mwbData_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection and
// bubble insertion for stalls and branch flushes. Feeds ALU2 (a, b, aluOp).
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_use_imm,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush,
    input  logic                  ex_hold,
    input  logic                  exm_reg_write,
    input  logic [REG_ADDR_W-1:0] exm_rd_addr,
    input  logic [DATA_W-1:0]     exm_result,
    input  logic                  mwb_reg_write,
    input  logic [REG_ADDR_W-1:0] mwb_rd_addr,
    input  logic [DATA_W-1:0]     mwb_result,
    output logic                  ex_valid,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  stall_id
);

    ExRegT             exReg_q;
    ExRegT             exReg_d;
    logic              loadUse;
    logic              rsRefresh;
    logic              rtRefresh;
    logic [DATA_W-1:0] rsFwd;
    logic [DATA_W-1:0] rtFwd;

    // A load in EX cannot forward its data yet, so a dependent ID instruction must wait one cycle.
    always_comb begin
        loadUse = 1'b0;
        if (exReg_q.valid && exReg_q.memRead && (exReg_q.rdAddr != '0) && id_valid) begin
            loadUse = (id_uses_rs && (id_rs_addr == exReg_q.rdAddr)) ||
                      (id_uses_rt && (id_rt_addr == exReg_q.rdAddr));
        end
    end

    assign stall_id = ex_hold | loadUse;

    // A writeback retiring while EX is frozen would otherwise be lost once it leaves MEM/WB.
    always_comb begin
        rsRefresh = mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == exReg_q.rsAddr);
        rtRefresh = mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == exReg_q.rtAddr);
    end

    // Next EX contents: hold beats flush, flush and load-use insert a bubble, otherwise capture ID.
    always_comb begin
        exReg_d = exReg_q;
        if (ex_hold) begin
            if (rsRefresh) begin
                exReg_d.rsData = mwb_result;
            end
            if (rtRefresh) begin
                exReg_d.rtData = mwb_result;
            end
        end else if (flush || loadUse) begin
            exReg_d = bubbleReg();
        end else begin
            exReg_d.valid    = id_valid;
            exReg_d.aluOp    = id_alu_op;
            exReg_d.rsAddr   = id_rs_addr;
            exReg_d.rtAddr   = id_rt_addr;
            exReg_d.rsData   = id_rs_data;
            exReg_d.rtData   = id_rt_data;
            exReg_d.imm      = id_imm;
            exReg_d.useImm   = id_use_imm;
            exReg_d.rdAddr   = id_rd_addr;
            exReg_d.regWrite = id_reg_write;
            exReg_d.memRead  = id_mem_read;
            exReg_d.memWrite = id_mem_write;
        end
    end

    // The ID/EX register itself; reset leaves a bubble so ALU2 sees a nop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exReg_q <= bubbleReg();
        end else begin
            exReg_q <= exReg_d;
        end
    end

    fwd_mux uRsFwd (
        .addr_i     (exReg_q.rsAddr),
        .latched_i  (exReg_q.rsData),
        .exmWrite_i (exm_reg_write),
        .exmAddr_i  (exm_rd_addr),
        .exmData_i  (exm_result),
        .mwbWrite_i (mwb_reg_write),
        .mwbAddr_i  (mwb_rd_addr),
        .mwbData_i  (mwb_result),
        .operand_o  (rsFwd)
    );

    fwd_mux uRtFwd (
        .addr_i     (exReg_q.rtAddr),
        .latched_i  (exReg_q.rtData),
        .exmWrite_i (exm_reg_write),
        .exmAddr_i  (exm_rd_addr),
        .exmData_i  (exm_result),
        .mwbWrite_i (mwb_reg_write),
        .mwbAddr_i  (mwb_rd_addr),
        .mwbData_i  (mwb_result),
        .operand_o  (rtFwd)
    );

    assign ex_valid      = exReg_q.valid;
    assign ex_alu_op     = exReg_q.aluOp;
    assign ex_a          = rsFwd;
    assign ex_b          = exReg_q.useImm ? exReg_q.imm : rtFwd;
    assign ex_store_data = rtFwd;
    assign ex_rd_addr    = exReg_q.rdAddr;
    assign ex_reg_write  = exReg_q.valid & exReg_q.regWrite;
    assign ex_mem_read   = exReg_q.valid & exReg_q.memRead;
    assign ex_mem_write  = exReg_q.valid & exReg_q.memWrite;

endmodule
